// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared types and constants for the SPI register arbiter.
//   - arb_state_t : arbiter FSM states
//   - grant_t     : which side was granted the bank last
//   - STAT_*_OFS  : status flag positions, counted down from the MSB of the
//                   status word so they stay correct for any REG_W >= 3
//   The round-robin grant policy is selected with the SPI_ARB_RR_EN macro.

package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPI_WR = 2'd1,
        ST_HOST   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_SPI  = 1'b0,
        GRANT_HOST = 1'b1
    } grant_t;

    localparam int STAT_OVERRUN_OFS  = 0;
    localparam int STAT_ADDR_ERR_OFS = 1;
    localparam int STAT_SPI_PEND_OFS = 2;

endpackage

// File: rtl/spi_reg_bank.sv
// spi_reg_bank
//   Register storage with one write port and two combinational read ports.
//   Out-of-range writes are dropped and out-of-range reads return 0.
// Ports:
//   clk, rstb       clock, asynchronous active-low reset (clears the bank)
//   we              write enable for this cycle
//   waddr, wdata    write address/data
//   waddr_oor       waddr is outside the implemented registers
//   raddr_a/rdata_a combinational read port A (SPI side)
//   raddr_b/rdata_b combinational read port B (host side)
//   regs            flattened bank contents, register 0 in the LSBs

module spi_reg_bank
    import spi_arb_pkg::*;
#(
    parameter int REG_W    = 8,
    parameter int NUM_REGS = 8
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      we,
    input  logic [REG_W-2:0]          waddr,
    input  logic [REG_W-1:0]          wdata,
    output logic                      waddr_oor,
    input  logic [REG_W-2:0]          raddr_a,
    output logic [REG_W-1:0]          rdata_a,
    input  logic [REG_W-2:0]          raddr_b,
    output logic [REG_W-1:0]          rdata_b,
    output logic [NUM_REGS*REG_W-1:0] regs
);

    logic [REG_W-1:0] bank [NUM_REGS];

    assign waddr_oor = (int'(waddr) >= NUM_REGS);

    // Storage; the address match below naturally drops out-of-range writes.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(waddr) == i) begin
                    bank[i] <= wdata;
                end
            end
        end
    end

    // Read port A; no match leaves the default 0 for out-of-range addresses.
    always_comb begin
        rdata_a = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(raddr_a) == i) begin
                rdata_a = bank[i];
            end
        end
    end

    // Read port B, same behaviour as port A.
    always_comb begin
        rdata_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(raddr_b) == i) begin
                rdata_b = bank[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs[g*REG_W +: REG_W] = bank[g];
        end
    endgenerate

endmodule

// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter
//   Shares the single write port of spi_reg_bank between posted SPI writes
//   and a local host. SPI writes land in a one-entry pending buffer; the FSM
//   then grants each bank cycle to either the pending write or the host.
//   Build option: define SPI_ARB_RR_EN for round-robin grants; otherwise a
//   pending SPI write always wins.
// Ports:
//   clk, rstb                clock, asynchronous active-low reset
//   ena                      global enable, low freezes all state
//   spi_addr/wdata/we        SPI application write interface
//   spi_rdata                combinational read of bank[spi_addr]
//   host_req/wr/addr/wdata   host request, held until host_gnt
//   host_gnt                 access executes in this cycle
//   host_rdata/host_rvalid   registered read data, valid the cycle after grant
//   clr_err                  clears the sticky overrun/address-error flags
//   status                   {overrun, addr_err, spi_pend, zeros}
//   regs                     flattened bank contents

module spi_reg_arbiter
    import spi_arb_pkg::*;
#(
    parameter int REG_W    = 8,
    parameter int NUM_REGS = 8
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    input  logic [REG_W-2:0]          spi_addr,
    input  logic [REG_W-1:0]          spi_wdata,
    input  logic                      spi_we,
    output logic [REG_W-1:0]          spi_rdata,
    input  logic                      host_req,
    input  logic                      host_wr,
    input  logic [REG_W-2:0]          host_addr,
    input  logic [REG_W-1:0]          host_wdata,
    output logic                      host_gnt,
    output logic [REG_W-1:0]          host_rdata,
    output logic                      host_rvalid,
    input  logic                      clr_err,
    output logic [REG_W-1:0]          status,
    output logic [NUM_REGS*REG_W-1:0] regs
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              spi_pend;
    logic [REG_W-2:0]  pend_addr;
    logic [REG_W-1:0]  pend_data;
    logic              overrun;
    logic              addr_err;
    logic              rvalid_q;
    logic [REG_W-1:0]  host_rdata_q;

    logic              bank_we;
    logic [REG_W-2:0]  bank_waddr;
    logic [REG_W-1:0]  bank_wdata;
    logic              bank_waddr_oor;
    logic [REG_W-1:0]  bank_rdata_b;
    logic              set_overrun;
    logic              set_addr_err;

`ifdef SPI_ARB_RR_EN
    grant_t            last_grant;
`endif

    // In ST_HOST the write address doubles as the read address, so its range
    // check covers host reads as well as all writes.
    assign bank_waddr = (state == ST_SPI_WR) ? pend_addr : host_addr;
    assign bank_wdata = (state == ST_SPI_WR) ? pend_data : host_wdata;
    assign bank_we    = ena && ((state == ST_SPI_WR) ||
                                ((state == ST_HOST) && host_wr));

    spi_reg_bank #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .clk       (clk),
        .rstb      (rstb),
        .we        (bank_we),
        .waddr     (bank_waddr),
        .wdata     (bank_wdata),
        .waddr_oor (bank_waddr_oor),
        .raddr_a   (spi_addr),
        .rdata_a   (spi_rdata),
        .raddr_b   (host_addr),
        .rdata_b   (bank_rdata_b),
        .regs      (regs)
    );

    // A reload during ST_SPI_WR is expected traffic, not an overrun.
    assign set_overrun  = ena && spi_we && spi_pend && (state != ST_SPI_WR);
    assign set_addr_err = ena && (state != ST_IDLE) && bank_waddr_oor;

    // Next-state logic; only the IDLE decision differs between policies.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
`ifdef SPI_ARB_RR_EN
                if (spi_pend && (!host_req || (last_grant == GRANT_HOST))) begin
`else
                if (spi_pend) begin
`endif
                    state_nxt = ST_SPI_WR;
                end else if (host_req) begin
                    state_nxt = ST_HOST;
                end
            end
            ST_SPI_WR: state_nxt = ST_IDLE;
            ST_HOST:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

`ifdef SPI_ARB_RR_EN
    // Remembers who was served last so contention alternates.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_grant <= GRANT_HOST;
        end else if (ena) begin
            if (state == ST_SPI_WR) begin
                last_grant <= GRANT_SPI;
            end else if (state == ST_HOST) begin
                last_grant <= GRANT_HOST;
            end
        end
    end
`endif

    // Pending buffer: a new strobe always wins over the commit-clear, which is
    // what keeps spi_pend set when a write is reloaded during ST_SPI_WR.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            spi_pend  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else if (ena) begin
            if (spi_we) begin
                spi_pend  <= 1'b1;
                pend_addr <= spi_addr;
                pend_data <= spi_wdata;
            end else if (state == ST_SPI_WR) begin
                spi_pend  <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            overrun  <= 1'b0;
            addr_err <= 1'b0;
        end else if (ena) begin
            overrun  <= set_overrun  | (overrun  & ~clr_err);
            addr_err <= set_addr_err | (addr_err & ~clr_err);
        end
    end

    // Host read return path, one cycle after the read grant.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rvalid_q     <= 1'b0;
            host_rdata_q <= '0;
        end else if (ena) begin
            rvalid_q <= (state == ST_HOST) && !host_wr;
            if ((state == ST_HOST) && !host_wr) begin
                host_rdata_q <= bank_rdata_b;
            end
        end
    end

    assign host_gnt    = ena && (state == ST_HOST);
    assign host_rvalid = ena && rvalid_q;
    assign host_rdata  = host_rdata_q;

    always_comb begin
        status = '0;
        status[REG_W-1-STAT_OVERRUN_OFS]  = overrun;
        status[REG_W-1-STAT_ADDR_ERR_OFS] = addr_err;
        status[REG_W-1-STAT_SPI_PEND_OFS] = spi_pend;
    end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// tb_spi_reg_arbiter
//   Self-checking bench for spi_reg_arbiter with the default parameters.
//   A table of single transactions exercises the basic SPI/host paths, then
//   hand-written sequences cover contention, overrun, reload during commit,
//   out-of-range access, enable freeze and reset in the middle of an access.
//   Contention expectations follow the SPI_ARB_RR_EN setting.

module tb_spi_reg_arbiter;

    localparam int REG_W    = 8;
    localparam int NUM_REGS = 8;

    localparam int OP_SPI_WR  = 0;
    localparam int OP_HOST_WR = 1;
    localparam int OP_HOST_RD = 2;

    localparam int BIT_OVR  = 7;
    localparam int BIT_AERR = 6;
    localparam int BIT_PEND = 5;

    typedef struct {
        int         op;
        logic [6:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    logic                      clk;
    logic                      rstb;
    logic                      ena;
    logic [REG_W-2:0]          spi_addr;
    logic [REG_W-1:0]          spi_wdata;
    logic                      spi_we;
    logic [REG_W-1:0]          spi_rdata;
    logic                      host_req;
    logic                      host_wr;
    logic [REG_W-2:0]          host_addr;
    logic [REG_W-1:0]          host_wdata;
    logic                      host_gnt;
    logic [REG_W-1:0]          host_rdata;
    logic                      host_rvalid;
    logic                      clr_err;
    logic [REG_W-1:0]          status;
    logic [NUM_REGS*REG_W-1:0] regs;

    int         checks;
    int         errors;
    logic [7:0] exp_bank [NUM_REGS];
    vec_t       vecs [10];

    spi_reg_arbiter #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .spi_addr    (spi_addr),
        .spi_wdata   (spi_wdata),
        .spi_we      (spi_we),
        .spi_rdata   (spi_rdata),
        .host_req    (host_req),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .clr_err     (clr_err),
        .status      (status),
        .regs        (regs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] reg_of(input int idx);
        return regs[idx*REG_W +: REG_W];
    endfunction

    function automatic logic [63:0] packed_model();
        logic [63:0] p;
        p = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            p[i*REG_W +: REG_W] = exp_bank[i];
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one table transaction with its fixed cycle timing and checks it.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        case (v.op)
            OP_SPI_WR: begin
                spi_addr  = v.addr;
                spi_wdata = v.data;
                spi_we    = 1'b1;
                tick();
                spi_we = 1'b0;
                checkOutput({tag, "_pend"}, status[BIT_PEND], 1'b1);
                tick();
                tick();
                checkOutput({tag, "_regs"}, reg_of(int'(v.addr)), v.exp);
                checkOutput({tag, "_spi_rdata"}, spi_rdata, v.exp);
                exp_bank[v.addr] = v.exp;
            end
            OP_HOST_WR: begin
                host_addr  = v.addr;
                host_wdata = v.data;
                host_wr    = 1'b1;
                host_req   = 1'b1;
                tick();
                checkOutput({tag, "_gnt"}, host_gnt, 1'b1);
                host_req = 1'b0;
                tick();
                checkOutput({tag, "_gnt_off"}, host_gnt, 1'b0);
                checkOutput({tag, "_regs"}, reg_of(int'(v.addr)), v.exp);
                exp_bank[v.addr] = v.exp;
            end
            default: begin
                host_addr = v.addr;
                host_wr   = 1'b0;
                host_req  = 1'b1;
                tick();
                checkOutput({tag, "_gnt"}, host_gnt, 1'b1);
                checkOutput({tag, "_rvalid_early"}, host_rvalid, 1'b0);
                host_req = 1'b0;
                tick();
                checkOutput({tag, "_rvalid"}, host_rvalid, 1'b1);
                checkOutput({tag, "_rdata"}, host_rdata, v.exp);
            end
        endcase
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rstb       = 1'b0;
        ena        = 1'b1;
        spi_addr   = '0;
        spi_wdata  = '0;
        spi_we     = 1'b0;
        host_req   = 1'b0;
        host_wr    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        clr_err    = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_bank[i] = 8'h00;
        end

        vecs[0] = '{OP_SPI_WR,  7'd3, 8'hA5, 8'hA5};
        vecs[1] = '{OP_HOST_RD, 7'd3, 8'h00, 8'hA5};
        vecs[2] = '{OP_HOST_WR, 7'd5, 8'h3C, 8'h3C};
        vecs[3] = '{OP_SPI_WR,  7'd0, 8'hFF, 8'hFF};
        vecs[4] = '{OP_HOST_RD, 7'd0, 8'h00, 8'hFF};
        vecs[5] = '{OP_HOST_RD, 7'd7, 8'h00, 8'h00};
        vecs[6] = '{OP_SPI_WR,  7'd7, 8'h81, 8'h81};
        vecs[7] = '{OP_HOST_RD, 7'd5, 8'h00, 8'h3C};
        vecs[8] = '{OP_HOST_WR, 7'd3, 8'h5B, 8'h5B};
        vecs[9] = '{OP_HOST_RD, 7'd3, 8'h00, 8'h5B};

        // Reset state
        tick();
        tick();
        checkOutput("rst_regs", regs, 64'h0);
        checkOutput("rst_status", status, 8'h00);
        checkOutput("rst_gnt", host_gnt, 1'b0);
        checkOutput("rst_rvalid", host_rvalid, 1'b0);
        checkOutput("rst_rdata", host_rdata, 8'h00);
        rstb = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i, vecs[i]);
        end
        checkOutput("table_regs", regs, packed_model());

        // Contention after a host grant: pending SPI write goes first,
        // host is granted two cycles after the commit and reads the new value.
        spi_addr  = 7'd1;
        spi_wdata = 8'h5A;
        spi_we    = 1'b1;
        tick();
        spi_we    = 1'b0;
        host_addr = 7'd1;
        host_wr   = 1'b0;
        host_req  = 1'b1;
        tick();
        checkOutput("cont1_gnt_c2", host_gnt, 1'b0);
        tick();
        checkOutput("cont1_gnt_c3", host_gnt, 1'b0);
        checkOutput("cont1_reg1", reg_of(1), 8'h5A);
        tick();
        checkOutput("cont1_gnt_c4", host_gnt, 1'b1);
        host_req = 1'b0;
        tick();
        checkOutput("cont1_rvalid", host_rvalid, 1'b1);
        checkOutput("cont1_rdata", host_rdata, 8'h5A);
        exp_bank[1] = 8'h5A;

        // Contention after an SPI grant.
        spi_addr  = 7'd4;
        spi_wdata = 8'h0F;
        spi_we    = 1'b1;
        tick();
        spi_we = 1'b0;
        tick();
        tick();
        checkOutput("cont2_pre_reg4", reg_of(4), 8'h0F);
        exp_bank[4] = 8'h0F;
        spi_addr  = 7'd2;
        spi_wdata = 8'h77;
        spi_we    = 1'b1;
        tick();
        spi_we    = 1'b0;
        host_addr = 7'd2;
        host_wr   = 1'b0;
        host_req  = 1'b1;
        tick();
`ifdef SPI_ARB_RR_EN
        checkOutput("cont2_gnt_c2", host_gnt, 1'b1);
        host_req = 1'b0;
        tick();
        checkOutput("cont2_rvalid", host_rvalid, 1'b1);
        checkOutput("cont2_rdata", host_rdata, 8'h00);
        checkOutput("cont2_reg2_early", reg_of(2), 8'h00);
        tick();
        tick();
        checkOutput("cont2_reg2", reg_of(2), 8'h77);
`else
        checkOutput("cont2_gnt_c2", host_gnt, 1'b0);
        tick();
        checkOutput("cont2_gnt_c3", host_gnt, 1'b0);
        tick();
        checkOutput("cont2_gnt_c4", host_gnt, 1'b1);
        host_req = 1'b0;
        tick();
        checkOutput("cont2_rvalid", host_rvalid, 1'b1);
        checkOutput("cont2_rdata", host_rdata, 8'h77);
        checkOutput("cont2_reg2", reg_of(2), 8'h77);
`endif
        exp_bank[2] = 8'h77;

        // Overrun: second strobe before the first commits; only 0x11 lands.
        spi_addr  = 7'd6;
        spi_wdata = 8'h22;
        spi_we    = 1'b1;
        tick();
        spi_wdata = 8'h11;
        tick();
        spi_we = 1'b0;
        checkOutput("ovr_flag", status[BIT_OVR], 1'b1);
        checkOutput("ovr_reg6_early", reg_of(6), 8'h00);
        tick();
        checkOutput("ovr_reg6", reg_of(6), 8'h11);
        exp_bank[6] = 8'h11;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("ovr_cleared", status, 8'h00);

        // Strobe during the commit cycle reloads the buffer without overrun.
        spi_addr  = 7'd4;
        spi_wdata = 8'h44;
        spi_we    = 1'b1;
        tick();
        spi_we = 1'b0;
        tick();
        spi_wdata = 8'h99;
        spi_we    = 1'b1;
        tick();
        spi_we = 1'b0;
        checkOutput("reload_reg4_first", reg_of(4), 8'h44);
        checkOutput("reload_status", status, 8'h20);
        tick();
        tick();
        checkOutput("reload_reg4_second", reg_of(4), 8'h99);
        checkOutput("reload_pend_clear", status[BIT_PEND], 1'b0);
        exp_bank[4] = 8'h99;

        // Out-of-range host write is dropped and flags addr_err.
        host_addr  = 7'd9;
        host_wdata = 8'hEE;
        host_wr    = 1'b1;
        host_req   = 1'b1;
        tick();
        checkOutput("oor_gnt", host_gnt, 1'b1);
        host_req = 1'b0;
        tick();
        checkOutput("oor_aerr", status[BIT_AERR], 1'b1);
        checkOutput("oor_regs", regs, packed_model());
        spi_addr = 7'd9;
        #1;
        checkOutput("oor_spi_rdata", spi_rdata, 8'h00);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("oor_cleared", status[BIT_AERR], 1'b0);

        // Enable low: no grant, strobes ignored, state resumes afterwards.
        ena       = 1'b0;
        host_addr = 7'd3;
        host_wr   = 1'b0;
        host_req  = 1'b1;
        spi_addr  = 7'd0;
        spi_wdata = 8'h00;
        spi_we    = 1'b1;
        tick();
        spi_we = 1'b0;
        tick();
        checkOutput("ena_gnt", host_gnt, 1'b0);
        checkOutput("ena_pend", status[BIT_PEND], 1'b0);
        ena = 1'b1;
        tick();
        checkOutput("ena_gnt_resume", host_gnt, 1'b1);
        host_req = 1'b0;
        tick();
        checkOutput("ena_rdata", host_rdata, 8'h5B);
        checkOutput("ena_reg0", reg_of(0), 8'hFF);

        // Reset asserted during a host write grant.
        host_addr  = 7'd0;
        host_wdata = 8'h3C;
        host_wr    = 1'b1;
        host_req   = 1'b1;
        tick();
        checkOutput("rmid_gnt", host_gnt, 1'b1);
        #2;
        rstb = 1'b0;
        #1;
        host_req = 1'b0;
        checkOutput("rmid_regs", regs, 64'h0);
        checkOutput("rmid_status", status, 8'h00);
        checkOutput("rmid_rdata", host_rdata, 8'h00);
        checkOutput("rmid_gnt_off", host_gnt, 1'b0);
        tick();
        rstb = 1'b1;
        tick();
        checkOutput("rmid_post_gnt", host_gnt, 1'b0);
        checkOutput("rmid_post_rvalid", host_rvalid, 1'b0);
        tick();
        checkOutput("rmid_post_gnt2", host_gnt, 1'b0);
        checkOutput("rmid_post_rvalid2", host_rvalid, 1'b0);
        checkOutput("rmid_post_regs", regs, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
